// File: rtl/spi_slave_fifo.sv
// SPI slave with RX/TX word FIFOs, all logic on clk; SCLK is oversampled.
// Define SPI_SLAVE_STATUS_EN to add sticky rx_overrun/tx_underrun flags.
module spi_slave_fifo #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          spi_sclk,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    input  logic                          spi_cs_n,
    output logic [WIDTH-1:0]              rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic [WIDTH-1:0]              tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          busy
`ifdef SPI_SLAVE_STATUS_EN
    ,
    output logic                          rx_overrun,
    output logic                          tx_underrun,
    input  logic                          status_clr
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WIDTH);
    localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

    generate
        if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32) || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
            $error("spi_slave_fifo: illegal WIDTH or FIFO_DEPTH");
        end
    endgenerate

    logic [2:0] sclk_q;
    logic [1:0] mosi_q;
    logic [1:0] cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= (CPOL != 0) ? 3'b111 : 3'b000;
            mosi_q <= '0;
            cs_q   <= 2'b11;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk};
            mosi_q <= {mosi_q[0], spi_mosi};
            cs_q   <= {cs_q[0], spi_cs_n};
        end
    end

    logic act, rise, fall, lead_e, trail_e, samp_e, shft_e;
    assign act     = ~cs_q[1];
    assign busy    = act;
    assign rise    = sclk_q[1] & ~sclk_q[2];
    assign fall    = ~sclk_q[1] & sclk_q[2];
    assign lead_e  = (CPOL != 0) ? fall : rise;
    assign trail_e = (CPOL != 0) ? rise : fall;
    assign samp_e  = act & ((CPHA != 0) ? trail_e : lead_e);
    assign shft_e  = act & ((CPHA != 0) ? lead_e : trail_e);

    logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [CW-1:0]    rx_bit_q;
    logic             rx_push;

    assign rx_sr_d = (MSB_FIRST != 0) ? {rx_sr_q[WIDTH-2:0], mosi_q[1]}
                                      : {mosi_q[1], rx_sr_q[WIDTH-1:1]};
    assign rx_push = samp_e && (rx_bit_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr_q  <= '0;
            rx_bit_q <= '0;
        end else if (!act) begin
            rx_bit_q <= '0;
        end else if (samp_e) begin
            rx_sr_q  <= rx_sr_d;
            rx_bit_q <= rx_bit_q + 1'b1;
        end
    end

    // RX FIFO: a push into a full FIFO still lands if the head leaves this cycle
    logic [WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]    rx_wp_q, rx_rp_q;
    logic [AW:0]      rx_lvl_q;
    logic             rx_full, rx_pop, rx_wr;

    assign rx_full  = rx_lvl_q == FULL;
    assign rx_valid = rx_lvl_q != '0;
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_wr    = rx_push && (!rx_full || rx_pop);
    assign rx_data  = rx_valid ? rx_mem[rx_rp_q] : '0;
    assign rx_level = rx_lvl_q;

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wp_q] <= rx_sr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_lvl_q <= '0;
        end else begin
            if (rx_wr)  rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop) rx_rp_q <= rx_rp_q + 1'b1;
            rx_lvl_q <= rx_lvl_q + (AW+1)'(rx_wr) - (AW+1)'(rx_pop);
        end
    end

    logic [WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]    tx_wp_q, tx_rp_q;
    logic [AW:0]      tx_lvl_q;
    logic             tx_push, tx_pop, tx_nempty;

    assign tx_ready  = tx_lvl_q != FULL;
    assign tx_push   = tx_valid && tx_ready;
    assign tx_nempty = tx_lvl_q != '0;
    assign tx_level  = tx_lvl_q;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_lvl_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            tx_lvl_q <= tx_lvl_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
        end
    end

    // tx_fresh_q marks a loaded word that has not lost any bit yet
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [CW-1:0]    tx_bit_q, tx_bit_d;
    logic             tx_fresh_q, tx_fresh_d, tx_load;

    always_comb begin
        tx_sr_d    = tx_sr_q;
        tx_bit_d   = tx_bit_q;
        tx_fresh_d = tx_fresh_q;
        tx_load    = 1'b0;
        if (!act) begin
            tx_bit_d = '0;
            if (CPHA == 0 && !tx_fresh_q) tx_load = 1'b1;
        end else if (shft_e) begin
            tx_bit_d = tx_bit_q + 1'b1;
            if (CPHA == 0) tx_load = tx_bit_q == LAST;
            else           tx_load = tx_bit_q == '0;
            if (!tx_load) begin
                tx_sr_d    = (MSB_FIRST != 0) ? {tx_sr_q[WIDTH-2:0], 1'b1}
                                              : {1'b1, tx_sr_q[WIDTH-1:1]};
                tx_fresh_d = 1'b0;
            end
        end
        if (tx_load) begin
            tx_sr_d    = tx_nempty ? tx_mem[tx_rp_q] : '1;
            tx_fresh_d = tx_nempty;
        end
    end

    assign tx_pop   = tx_load && tx_nempty;
    assign spi_miso = (MSB_FIRST != 0) ? tx_sr_q[WIDTH-1] : tx_sr_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr_q    <= '1;
            tx_bit_q   <= '0;
            tx_fresh_q <= 1'b0;
        end else begin
            tx_sr_q    <= tx_sr_d;
            tx_bit_q   <= tx_bit_d;
            tx_fresh_q <= tx_fresh_d;
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    logic rx_drop, tx_fill, ovr_q, unr_q;
    assign rx_drop = rx_push && !rx_wr;
    assign tx_fill = tx_load && !tx_nempty && act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
            unr_q <= 1'b0;
        end else begin
            if (rx_drop)         ovr_q <= 1'b1;
            else if (status_clr) ovr_q <= 1'b0;
            if (tx_fill)         unr_q <= 1'b1;
            else if (status_clr) unr_q <= 1'b0;
        end
    end

    assign rx_overrun  = ovr_q;
    assign tx_underrun = unr_q;
`endif

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: one 8-bit mode-0 slave plus four 16-bit slaves.
// Index 0 is the 8-bit slave; 1..4 are 16-bit SPI modes 0..3 (4 is LSB-first).
module tb_spi_slave_fifo;
    localparam int HALF = 60;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0] m_sclk, m_cs, m_mosi;
    logic [4:0] r_rdy, t_v;
    wire  [4:0] s_miso, s_rxv, s_txr, s_bsy;
    logic [7:0]  t8;
    logic [7:0]  r8;
    logic [2:0]  rl8, tl8;
    logic [15:0] t16 [1:4];
    logic [15:0] r16 [1:4];
    logic [2:0]  rl16 [1:4];
    logic [2:0]  tl16 [1:4];
`ifdef SPI_SLAVE_STATUS_EN
    wire  [4:0] s_ovr, s_unr;
    logic [4:0] s_clr;
`endif

    spi_slave_fifo #(
        .WIDTH(8), .FIFO_DEPTH(4), .CPOL(0), .CPHA(0), .MSB_FIRST(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(m_sclk[0]), .spi_mosi(m_mosi[0]),
        .spi_miso(s_miso[0]), .spi_cs_n(m_cs[0]),
        .rx_data(r8), .rx_valid(s_rxv[0]), .rx_ready(r_rdy[0]),
        .tx_data(t8), .tx_valid(t_v[0]), .tx_ready(s_txr[0]),
        .rx_level(rl8), .tx_level(tl8), .busy(s_bsy[0])
`ifdef SPI_SLAVE_STATUS_EN
        , .rx_overrun(s_ovr[0]), .tx_underrun(s_unr[0]), .status_clr(s_clr[0])
`endif
    );

    for (genvar g = 1; g < 5; g++) begin : g_m16
        spi_slave_fifo #(
            .WIDTH(16), .FIFO_DEPTH(4), .CPOL((g-1)/2), .CPHA((g-1)%2),
            .MSB_FIRST((g == 4) ? 0 : 1)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .spi_sclk(m_sclk[g]), .spi_mosi(m_mosi[g]),
            .spi_miso(s_miso[g]), .spi_cs_n(m_cs[g]),
            .rx_data(r16[g]), .rx_valid(s_rxv[g]), .rx_ready(r_rdy[g]),
            .tx_data(t16[g]), .tx_valid(t_v[g]), .tx_ready(s_txr[g]),
            .rx_level(rl16[g]), .tx_level(tl16[g]), .busy(s_bsy[g])
`ifdef SPI_SLAVE_STATUS_EN
            , .rx_overrun(s_ovr[g]), .tx_underrun(s_unr[g]), .status_clr(s_clr[g])
`endif
        );
    end

    int n_chk, n_pass;
    logic [7:0]  tq[$];
    logic [7:0]  rq[$];
    logic        e_ovr, e_unr;
    logic [31:0] mo [8];
    logic [31:0] mi [8];
    logic [31:0] junk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] rxd(input int d);
        if (d == 0) return {24'h0, r8};
        return {16'h0, r16[d]};
    endfunction

    function automatic int exp_tl();
        return (tq.size() == 0) ? 0 : tq.size() - 1;
    endfunction

    task automatic push(input int d, input logic [31:0] w);
        @(negedge clk);
        if (d == 0) t8 = w[7:0];
        else t16[d] = w[15:0];
        t_v[d] = 1'b1;
        @(negedge clk);
        t_v[d] = 1'b0;
    endtask

    task automatic pop_chk(input int d, input logic [31:0] exp);
        @(negedge clk);
        chk("rx_valid", {31'h0, s_rxv[d]}, 32'h1);
        chk("rx_data", rxd(d), exp);
        r_rdy[d] = 1'b1;
        @(negedge clk);
        r_rdy[d] = 1'b0;
    endtask

    task automatic clr(input int d);
`ifdef SPI_SLAVE_STATUS_EN
        @(negedge clk);
        s_clr[d] = 1'b1;
        @(negedge clk);
        s_clr[d] = 1'b0;
`endif
        if (d == 0) begin
            e_ovr = 1'b0;
            e_unr = 1'b0;
        end
    endtask

    task automatic stat8();
`ifdef SPI_SLAVE_STATUS_EN
        @(negedge clk);
        chk("rx_overrun", {31'h0, s_ovr[0]}, {31'h0, e_ovr});
        chk("tx_underrun", {31'h0, s_unr[0]}, {31'h0, e_unr});
`endif
    endtask

    // Master side of one word (or its first nb bits) in the slave's mode
    task automatic spi_word(input int d, input logic [31:0] dout, input int nb,
                            output logic [31:0] din);
        int w, b;
        logic cpol, cpha, lsb;
        w    = (d == 0) ? 8 : 16;
        cpol = (d == 3 || d == 4);
        cpha = (d == 2 || d == 4);
        lsb  = (d == 4);
        din  = '0;
        for (int i = 0; i < nb; i++) begin
            b = lsb ? i : w - 1 - i;
            if (!cpha) begin
                m_mosi[d] = dout[b];
                #HALF;
                m_sclk[d] = ~cpol;
                din[b] = s_miso[d];
                #HALF;
                m_sclk[d] = cpol;
            end else begin
                m_sclk[d] = ~cpol;
                m_mosi[d] = dout[b];
                #HALF;
                m_sclk[d] = cpol;
                din[b] = s_miso[d];
                #HALF;
            end
        end
    endtask

    task automatic sess(input int d, input int n);
        repeat (4) @(negedge clk);
        m_cs[d] = 1'b0;
        #HALF;
        for (int k = 0; k < n; k++) spi_word(d, mo[k], (d == 0) ? 8 : 16, mi[k]);
        #HALF;
        m_cs[d] = 1'b1;
        #(2*HALF);
        @(negedge clk);
    endtask

    task automatic fill_rand(input int n);
        for (int k = 0; k < n; k++) mo[k] = 32'($urandom_range(0, 255));
    endtask

    task automatic push8(input int n);
        logic [7:0] v;
        for (int k = 0; k < n; k++) begin
            v = 8'($urandom_range(0, 255));
            push(0, {24'h0, v});
            tq.push_back(v);
        end
        repeat (4) @(negedge clk);
    endtask

    // Full-word session on the 8-bit slave, judged against the queue model
    task automatic run8(input int n);
        logic [7:0] ex [8];
        for (int k = 0; k < n; k++) ex[k] = (tq.size() != 0) ? tq.pop_front() : 8'hFF;
        sess(0, n);
        for (int k = 0; k < n; k++) begin
            chk("miso_word", mi[k], {24'h0, ex[k]});
            if (rq.size() < 4) rq.push_back(mo[k][7:0]);
            else e_ovr = 1'b1;
        end
        if (tq.size() == 0) e_unr = 1'b1;
        chk("rx_level", {29'h0, rl8}, rq.size());
        chk("tx_level", {29'h0, tl8}, exp_tl());
        stat8();
    endtask

    task automatic drain8();
        while (rq.size() != 0) pop_chk(0, {24'h0, rq.pop_front()});
        chk("rx_level_drained", {29'h0, rl8}, 32'h0);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, ".rx_valid"}, {31'h0, s_rxv[0]}, 32'h0);
        chk({tag, ".rx_data"}, {24'h0, r8}, 32'h0);
        chk({tag, ".tx_ready"}, {31'h0, s_txr[0]}, 32'h1);
        chk({tag, ".rx_level"}, {29'h0, rl8}, 32'h0);
        chk({tag, ".tx_level"}, {29'h0, tl8}, 32'h0);
        chk({tag, ".busy"}, {31'h0, s_bsy[0]}, 32'h0);
        chk({tag, ".miso"}, {31'h0, s_miso[0]}, 32'h1);
`ifdef SPI_SLAVE_STATUS_EN
        chk({tag, ".rx_overrun"}, {31'h0, s_ovr[0]}, 32'h0);
        chk({tag, ".tx_underrun"}, {31'h0, s_unr[0]}, 32'h0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        m_sclk = 5'b11000;
        m_cs = 5'b11111;
        m_mosi = '0;
        r_rdy = '0;
        t_v = '0;
        t8 = '0;
        for (int i = 1; i < 5; i++) t16[i] = '0;
`ifdef SPI_SLAVE_STATUS_EN
        s_clr = '0;
`endif
        e_ovr = 1'b0;
        e_unr = 1'b0;
        repeat (3) @(negedge clk);
        rst_chk("in_reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_chk("after_reset");

        push(0, 32'hA5);
        tq.push_back(8'hA5);
        repeat (4) @(negedge clk);
        mo[0] = 32'h3C;
        run8(1);
        chk("rx_3c", {24'h0, r8}, 32'h3C);
        drain8();
        clr(0);
        stat8();

        push8(3);
        fill_rand(4);
        run8(4);
        chk("fourth_ff", mi[3], 32'hFF);
        drain8();
        clr(0);
        stat8();

        fill_rand(5);
        run8(5);
        chk("overrun_level", {29'h0, rl8}, 32'h4);
        drain8();
        clr(0);
        stat8();

        push8(2);
        @(negedge clk);
        m_cs[0] = 1'b0;
        #HALF;
        spi_word(0, 32'($urandom_range(0, 255)), 3, junk);
        #HALF;
        m_cs[0] = 1'b1;
        #(2*HALF);
        @(negedge clk);
        if (tq.size() != 0) void'(tq.pop_front());
        chk("partial_rx_level", {29'h0, rl8}, 32'h0);
        chk("partial_tx_level", {29'h0, tl8}, exp_tl());
        fill_rand(1);
        run8(1);
        drain8();
        clr(0);

        for (int it = 0; it < 12; it++) begin
            push8($urandom_range(0, 4 - tq.size()));
            chk("rand_tx_level", {29'h0, tl8}, exp_tl());
            fill_rand(2);
            run8($urandom_range(1, 3));
            drain8();
            clr(0);
            stat8();
        end

        for (int d = 1; d < 5; d++) begin
            push(d, 32'hBEEF);
            push(d, 32'h1234);
            repeat (4) @(negedge clk);
            mo[0] = 32'h1234;
            mo[1] = 32'hBEEF;
            sess(d, 2);
            chk("m16_miso0", mi[0], 32'hBEEF);
            chk("m16_miso1", mi[1], 32'h1234);
            chk("m16_rx_level", {29'h0, rl16[d]}, 32'h2);
            pop_chk(d, 32'h1234);
            pop_chk(d, 32'hBEEF);
        end

        push8(1);
        @(negedge clk);
        m_cs[0] = 1'b0;
        #HALF;
        spi_word(0, 32'h5A, 8, mi[0]);
        spi_word(0, 32'hFF, 4, junk);
        chk("mid_busy", {31'h0, s_bsy[0]}, 32'h1);
        chk("mid_rx_level", {29'h0, rl8}, 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        rst_chk("async_reset");
        m_cs[0] = 1'b1;
        tq.delete();
        rq.delete();
        e_ovr = 1'b0;
        e_unr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_chk("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_slave_fifo.md
SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 8: bits per word; legal values 8, 16 or 32.
- FIFO_DEPTH, default 4: entries per FIFO; power of 2, at least 2.
- CPOL, default 0: SCLK idle level.
- CPHA, default 0: 0 samples on the leading edge, 1 samples on the trailing edge.
- MSB_FIRST, default 1: 1 sends MSB first, 0 sends LSB first.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: the single system clock.
- rst_n, in, 1: reset; asynchronous, active-low.
- spi_sclk, in, 1: SPI clock; asynchronous to clk.
- spi_mosi, in, 1: master-out data.
- spi_miso, out, 1: slave-out data.
- spi_cs_n, in, 1: chip select, active-low.
- rx_data, out, WIDTH: head of the RX FIFO.
- rx_valid, out, 1: RX FIFO not empty.
- rx_ready, in, 1: pop the RX FIFO.
- tx_data, in, WIDTH: word to push into the TX FIFO.
- tx_valid, in, 1: push request.
- tx_ready, out, 1: TX FIFO not full.
- rx_level, out, clog2(FIFO_DEPTH)+1: RX FIFO occupancy.
- tx_level, out, clog2(FIFO_DEPTH)+1: TX FIFO occupancy.
- busy, out, 1: synchronized CS is active.

REQ-003 An illegal WIDTH or FIFO_DEPTH SHALL cause an elaboration error.

Function
REQ-004 spi_sclk, spi_mosi and spi_cs_n SHALL each pass through a two-flop synchronizer; SCLK SHALL get a third flop used only for edge detection.
- Supported SCLK rate: up to clk/8.

REQ-005 Edge definitions SHALL be:
- Leading edge: rising when CPOL=0, falling when CPOL=1.
- Sample edge: leading edge when CPHA=0, trailing edge when CPHA=1.
- Shift edge: the opposite edge.

REQ-006 RX path, per sample edge while busy:
- Shift synchronized MOSI into the RX shift register in the MSB_FIRST order.
- After WIDTH samples, push the assembled word into the RX FIFO.
- The push SHALL complete within 2 clk of the final sample edge.

REQ-007 If the RX FIFO is full at push time, the word SHALL be dropped, unless the application pops in the same cycle, in which case the push is accepted.

REQ-008 RX FIFO output SHALL be first-word-fall-through:
- rx_valid = not empty; rx_data = head entry.
- A pop occurs on clk when rx_valid && rx_ready.

REQ-009 TX FIFO input handshake:
- A push occurs when tx_valid && tx_ready.
- tx_ready depends only on "not full"; a pop in the same cycle does not raise it.

REQ-010 spi_miso SHALL drive the current output bit of the TX shift register (MSB or LSB per MSB_FIRST) at all times; it is not gated by CS.

REQ-011 TX load timing:
- CPHA=0: while CS is inactive, if the TX shift register holds no unsent word and the FIFO is non-empty, pop into it (preload). Also load on the WIDTH-th shift edge of each word.
- CPHA=1: load on the first shift edge of each word.
- On all other shift edges, shift by one bit.

REQ-012 A load with the TX FIFO empty SHALL load all-ones (the underrun fill).

REQ-013 CS deasserting mid-word SHALL:
- Discard the partial RX word.
- Zero both bit counters.
- Drop a partially shifted TX word.
- Retain a preloaded TX word that has not been shifted.

REQ-014 Levels SHALL be exact:
- Simultaneous push and pop leaves the level unchanged.
- Level never exceeds FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-015 rst_n low SHALL immediately clear all state, giving:
- rx_valid=0, rx_data=0, tx_ready=1, rx_level=0, tx_level=0, busy=0.
- TX shift register all-ones, so spi_miso=1.
- Status flags (when compiled in) = 0.

REQ-016 rst_n deassertion is synchronous to clk; this is guaranteed by the system reset controller.

Configuration
REQ-017 With SPI_SLAVE_STATUS_EN defined, the following SHALL be added:
- Output rx_overrun (1): sticky; set when an RX word is dropped.
- Output tx_underrun (1): sticky; set on an all-ones fill load while busy.
- Input status_clr (1): clears both flags on clk; a set in the same cycle wins.

REQ-018 Without SPI_SLAVE_STATUS_EN, those ports and flags SHALL be absent; all other behaviour is unchanged.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- WIDTH=8, CPOL=0, CPHA=0: push 0xA5, then master sends 0x3C. MISO returns 0xA5; rx_data=0x3C; rx_level=1.
- Run all four CPOL/CPHA modes with WIDTH=16: exchange 0x1234 and 0xBEEF. Both ends receive them bit-exact.
- FIFO_DEPTH=4: push 3 words, CS held for 4 words. The 4th word on MISO reads 0xFF and tx_underrun=1.
- Master sends 5 words with rx_ready=0: rx_level=4, 5th word dropped, rx_overrun=1. status_clr clears the flag.
- CS released after 3 bits of a word: rx_level unchanged. The next full transfer is received correctly.
- rst_n pulsed low mid-transfer: all outputs return to their reset values, with no clk edge required.
